// File: rtl/adder_rr_arbiter_if.sv
// adder_rr_arbiter_if: handshake/bus bundle between the requester lanes and the
// shared-adder arbiter.
//   req_valid/req_ready  per-requester valid/ready (NUM_REQ bits)
//   req_a/req_b          packed signed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_cin              per-requester carry-in
//   res_valid/res_ready  result handshake
//   res_sum/res_cout/res_ovf/res_id  registered result and the requester that produced it
interface adder_rr_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            req_cin;
    logic                          res_valid;
    logic                          res_ready;
    logic [DATA_WIDTH-1:0]         res_sum;
    logic                          res_cout;
    logic                          res_ovf;
    logic [ID_W-1:0]               res_id;

    // Requester / result-consumer side
    modport master (
        output req_valid, req_a, req_b, req_cin, res_ready,
        input  req_ready, res_valid, res_sum, res_cout, res_ovf, res_id
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, req_cin, res_ready,
        output req_ready, res_valid, res_sum, res_cout, res_ovf, res_id
    );
endinterface

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: shares one carry-look-ahead Adder among NUM_REQ requesters
// with round-robin arbitration. The result is registered (1-cycle latency) and
// held under res_ready backpressure; a new accept may replace a result that is
// draining in the same cycle, giving one operation per cycle.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   adder_rr_arbiter_if.slave (request and result handshakes)

// Adder: DATA_WIDTH carry-look-ahead adder built from 4-bit lookahead slices,
// carries rippling between slices. DATA_WIDTH must be a multiple of 4.
//   a, b, cin -> sum (mod 2^DATA_WIDTH), cout (unsigned carry-out)
module Adder #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout
);
    localparam int NSLICE = DATA_WIDTH / 4;

    logic [NSLICE:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[NSLICE];

    for (genvar s = 0; s < NSLICE; s++) begin : g_slice
        logic [3:0] g, p;
        logic [4:0] c;

        assign g    = a[4*s +: 4] & b[4*s +: 4];
        assign p    = a[4*s +: 4] ^ b[4*s +: 4];
        assign c[0] = carry[s];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c[0]);
        assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

        assign sum[4*s +: 4] = p ^ c[3:0];
        assign carry[s+1]    = c[4];
    end
endmodule

module adder_rr_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4
) (
    input  logic                clk,
    input  logic                rst,
    adder_rr_arbiter_if.slave   bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e                state_q, state_d;
    logic [ID_W-1:0]       ptr_q;       // last granted requester
    logic [DATA_WIDTH-1:0] sum_q;
    logic                  cout_q;
    logic                  ovf_q;
    logic [ID_W-1:0]       id_q;

    logic                  win_found;
    logic [ID_W-1:0]       win_id;
    logic [NUM_REQ-1:0]    gnt;
    logic [DATA_WIDTH-1:0] a_sel, b_sel;
    logic                  cin_sel;
    logic                  can_accept;
    logic                  accept;
    logic [DATA_WIDTH-1:0] add_sum;
    logic                  add_cout;
    logic                  add_ovf;

    // Round-robin search from ptr_q+1 upward, then wrap to 0..ptr_q.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        gnt       = '0;
        a_sel     = '0;
        b_sel     = '0;
        cin_sel   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && bus.req_valid[i] && (i > int'(ptr_q))) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
                gnt[i]    = 1'b1;
                a_sel     = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
                b_sel     = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
                cin_sel   = bus.req_cin[i];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && bus.req_valid[i] && (i <= int'(ptr_q))) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
                gnt[i]    = 1'b1;
                a_sel     = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
                b_sel     = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
                cin_sel   = bus.req_cin[i];
            end
        end
    end

    Adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
        .a    (a_sel),
        .b    (b_sel),
        .cin  (cin_sel),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Signed overflow: like-signed operands producing a differently-signed sum.
    assign add_ovf = (a_sel[DATA_WIDTH-1] == b_sel[DATA_WIDTH-1])
                   & (add_sum[DATA_WIDTH-1] != a_sel[DATA_WIDTH-1]);

    assign can_accept    = (state_q == EMPTY) || bus.res_ready;
    assign bus.req_ready = (can_accept && !rst) ? gnt : '0;
    assign accept        = win_found && can_accept && !rst;

    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = FULL;
        else if (state_q == FULL && bus.res_ready)
            state_d = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q  <= win_id;
                sum_q  <= add_sum;
                cout_q <= add_cout;
                ovf_q  <= add_ovf;
                id_q   <= win_id;
            end
        end
    end

    assign bus.res_valid = (state_q == FULL);
    assign bus.res_sum   = sum_q;
    assign bus.res_cout  = cout_q;
    assign bus.res_ovf   = ovf_q;
    assign bus.res_id    = id_q;
endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one instance of the team's DATA_WIDTH carry-look-ahead `Adder` among NUM_REQ requesters.
- Arbitration is round-robin. Each requester uses a valid/ready handshake.
- The selected operands drive the single adder. The result is registered and returned with the requester ID, under result-side backpressure.
- Sits between the accumulator/filter lanes and the shared adder datapath.

Parameters:
DATA_WIDTH, 16, operand/sum width; must be a multiple of 4 (adder built from 4-bit CLA slices)
NUM_REQ, 4, number of requesters; 2..16
ID_W, $clog2(NUM_REQ), derived local parameter; width of res_id

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester operation valid
req_ready  output  NUM_REQ  per-requester accept; at most one bit set
req_a  input  NUM_REQ*DATA_WIDTH  signed operand A; requester i in bits [i*DATA_WIDTH +: DATA_WIDTH]
req_b  input  NUM_REQ*DATA_WIDTH  signed operand B; same packing
req_cin  input  NUM_REQ  carry-in per requester
res_valid  output  1  result register holds a valid result
res_ready  input  1  downstream accepts the result
res_sum  output  DATA_WIDTH  signed sum a+b+cin, modulo 2^DATA_WIDTH
res_cout  output  1  adder carry-out (unsigned carry)
res_ovf  output  1  signed overflow: a and b have the same sign and sum has a different sign
res_id  output  ID_W  index of the requester that produced the result

Behaviour:
- Reset:
  - Synchronous; effective on the clk edge where rst=1; overrides all other activity.
  - res_valid=0, res_sum=0, res_cout=0, res_ovf=0, res_id=0.
  - Last-grant pointer = NUM_REQ-1, so requester 0 has top priority after reset.
  - req_ready=0 while rst=1.
  - Reset mid-operation discards the held result. No request is accepted on a reset cycle.
- Two-state FSM:
  - EMPTY (res_valid=0) and FULL (res_valid=1).
  - can_accept = EMPTY, or (FULL and res_ready).
- Arbitration:
  - Combinational, round-robin. Search starts at pointer+1 mod NUM_REQ and wraps.
  - The first index with req_valid=1 is the winner.
  - req_ready[winner] = can_accept. All other req_ready bits = 0.
  - req_ready depends combinationally on req_valid and res_ready. Requesters must not make req_valid depend on req_ready.
- Accept:
  - An accept is req_valid[i] & req_ready[i] at a clk edge.
  - On accept: res_sum/res_cout/res_ovf latch the adder output for requester i's a, b, cin; res_id=i; res_valid=1; pointer=i.
  - The pointer changes only on accept.
- Latency and throughput:
  - Latency is exactly 1 cycle from accept edge to res_valid.
  - Throughput is 1 operation/cycle while res_ready=1.
- Result drain:
  - FULL and res_ready=1 with no accept: go to EMPTY; res_valid=0. Data fields hold their last values.
  - FULL and res_ready=1 with an accept in the same cycle: stay FULL with the new result (back-to-back, no bubble).
  - FULL and res_ready=0: all res_* hold stable and every req_ready=0.
- Requester obligations:
  - Once req_valid[i]=1, requester i holds req_valid and its operands stable until accepted.
  - The block does not check this.
- Fairness:
  - With all requesters continuously valid and res_ready=1, grants cycle 0,1,…,NUM_REQ-1,0,…
  - A requester waits at most NUM_REQ-1 accepts before service.
- Idle: no req_valid means no accept; the pointer holds.
- Arithmetic:
  - The `Adder` is instantiated unchanged on the muxed operands.
  - res_cout = Adder cout.
  - res_ovf = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]). cin is included in the sum, so this is true two's-complement overflow.

Test Plan:
1. Reset, then requester 2 only: a=0x0005, b=0x0003, cin=1, res_ready=1.
   -> req_ready=0100 in the same cycle. Next cycle: res_valid=1, res_sum=0x0009, res_cout=0, res_ovf=0, res_id=2.
2. All 4 requesters valid continuously, res_ready=1.
   -> Accepts in order 0,1,2,3,0,1 on consecutive cycles. res_id follows one cycle later with no bubbles.
3. Requester 1: a=0x7FFF, b=0x0001, cin=0.
   -> res_sum=0x8000, res_ovf=1, res_cout=0.
   Then a=0xFFFF, b=0x0001, cin=0.
   -> res_sum=0x0000, res_cout=1, res_ovf=0.
4. res_ready=0 for 5 cycles while requesters 0 and 3 are valid.
   -> res_* stable, req_ready=0000 throughout. On res_ready=1, the next requester in round-robin order is accepted in that same cycle and its result appears the next cycle.
5. Assert rst while FULL with requester 1 waiting.
   -> Next cycle res_valid=0, res_sum=0, res_id=0, pointer reset. The first post-reset accept goes to the lowest valid index.
6. Requester 3 valid alone, then requesters 0 and 3 both valid.
   -> After granting 3, the next grant is 0 (wrap-around). The pointer is unchanged on idle cycles between the two.
